// File: rtl/alu_result_collector.sv
// rtl/alu_result_collector.sv - collects ALU_TOP unit results into a first-word-fall-through FIFO
module alu_result_collector #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_issue,
    input  logic [3:0]                 ALU_FUN,
    input  logic [DATA_W-1:0]          Arith_Out,
    input  logic [DATA_W-1:0]          Logic_Out,
    input  logic [DATA_W-1:0]          CMP_Out,
    input  logic [DATA_W-1:0]          Shift_Out,
    input  logic                       Arith_Flag,
    input  logic                       Logic_Flag,
    input  logic                       CMP_Flag,
    input  logic                       Shift_Flag,
    input  logic                       res_ready,
    input  logic                       err_clr,
    output logic                       res_valid,
    output logic [DATA_W-1:0]          res_data,
    output logic [3:0]                 res_fun,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       issue_ready,
    output logic                       flag_err,
    output logic                       ovf_err,
    output logic [7:0]                 drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] LIMIT_CNT = (AW+2)'(DEPTH);

    logic              pend_v;
    logic [3:0]        pend_fun;
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [3:0]        mem_fun  [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    logic [DATA_W-1:0] sel_data;
    logic              sel_flag;
    logic              other_flags;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic              flag_event;

    // Route the unit addressed by the pending opcode; any other unit flag raised is a protocol error
    always_comb begin
        sel_data    = Arith_Out;
        sel_flag    = Arith_Flag;
        other_flags = Logic_Flag | CMP_Flag | Shift_Flag;
        case (pend_fun[3:2])
            2'b00: begin
                sel_data    = Arith_Out;
                sel_flag    = Arith_Flag;
                other_flags = Logic_Flag | CMP_Flag | Shift_Flag;
            end
            2'b01: begin
                sel_data    = Logic_Out;
                sel_flag    = Logic_Flag;
                other_flags = Arith_Flag | CMP_Flag | Shift_Flag;
            end
            2'b10: begin
                sel_data    = CMP_Out;
                sel_flag    = CMP_Flag;
                other_flags = Arith_Flag | Logic_Flag | Shift_Flag;
            end
            default: begin
                sel_data    = Shift_Out;
                sel_flag    = Shift_Flag;
                other_flags = Arith_Flag | Logic_Flag | CMP_Flag;
            end
        endcase
    end

    assign full       = (count == FULL_CNT);
    assign res_valid  = (count != '0);
    assign pop        = res_valid & res_ready;
    // A full FIFO still takes the new result when the head leaves on the same edge
    assign push       = pend_v & (~full | pop);
    assign drop       = pend_v & full & ~pop;
    assign flag_event = pend_v & (~sel_flag | other_flags);

    assign res_data    = res_valid ? mem_data[rd_ptr] : '0;
    assign res_fun     = res_valid ? mem_fun[rd_ptr]  : 4'b0000;
    assign fifo_count  = count;
    assign issue_ready = (({1'b0, count}) + (AW+2)'(pend_v)) < LIMIT_CNT;

    // Track the in-flight ALU operation, one cycle behind the issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v   <= 1'b0;
            pend_fun <= 4'b0000;
        end else begin
            pend_v   <= alu_issue;
            pend_fun <= ALU_FUN;
        end
    end

    // Result storage; contents are only observed through valid entries so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= sel_data;
            mem_fun[wr_ptr]  <= pend_fun;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth makes pointer wrap implicit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error status; an error on the clearing edge survives the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_err <= 1'b0;
            ovf_err  <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            flag_err <= flag_event | (flag_err & ~err_clr);
            ovf_err  <= drop | (ovf_err & ~err_clr);
            if (err_clr)
                drop_cnt <= drop ? 8'd1 : 8'd0;
            else if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_alu_result_collector.sv
// tb/tb_alu_result_collector.sv - directed self-checking bench for alu_result_collector
module tb_alu_result_collector;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_issue;
    logic [3:0]  alu_fun;
    logic [15:0] op_a, op_b;
    logic [15:0] arith_out, logic_out, cmp_out, shift_out;
    logic        arith_f, logic_f, cmp_f, shift_f;
    logic        force_arith;
    logic        res_ready, err_clr;
    logic        res_valid;
    logic [15:0] res_data;
    logic [3:0]  res_fun;
    logic [2:0]  fifo_count;
    logic        issue_ready, flag_err, ovf_err;
    logic [7:0]  drop_cnt;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    alu_result_collector #(.DATA_W(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .alu_issue(alu_issue), .ALU_FUN(alu_fun),
        .Arith_Out(arith_out), .Logic_Out(logic_out), .CMP_Out(cmp_out), .Shift_Out(shift_out),
        .Arith_Flag(arith_f | force_arith), .Logic_Flag(logic_f), .CMP_Flag(cmp_f), .Shift_Flag(shift_f),
        .res_ready(res_ready), .err_clr(err_clr), .res_valid(res_valid), .res_data(res_data),
        .res_fun(res_fun), .fifo_count(fifo_count), .issue_ready(issue_ready),
        .flag_err(flag_err), .ovf_err(ovf_err), .drop_cnt(drop_cnt)
    );

    // Stand-in for ALU_TOP: one-cycle latency, only the addressed unit raises its flag
    always @(posedge clk) begin
        arith_out <= 16'h0; logic_out <= 16'h0; cmp_out <= 16'h0; shift_out <= 16'h0;
        arith_f <= 1'b0; logic_f <= 1'b0; cmp_f <= 1'b0; shift_f <= 1'b0;
        if (alu_issue) begin
            case (alu_fun[3:2])
                2'b00: begin
                    arith_f <= 1'b1;
                    case (alu_fun[1:0])
                        2'b00: arith_out <= op_a + op_b;
                        2'b01: arith_out <= op_a - op_b;
                        2'b10: arith_out <= op_a * op_b;
                        default: arith_out <= op_a / op_b;
                    endcase
                end
                2'b01: begin
                    logic_f <= 1'b1;
                    case (alu_fun[1:0])
                        2'b00: logic_out <= op_a & op_b;
                        2'b01: logic_out <= op_a | op_b;
                        2'b10: logic_out <= ~(op_a & op_b);
                        default: logic_out <= ~(op_a | op_b);
                    endcase
                end
                2'b10: begin
                    cmp_f <= 1'b1;
                    case (alu_fun[1:0])
                        2'b01: cmp_out <= (op_a == op_b) ? 16'd1 : 16'd0;
                        2'b10: cmp_out <= (op_a > op_b) ? 16'd2 : 16'd0;
                        2'b11: cmp_out <= (op_a < op_b) ? 16'd3 : 16'd0;
                        default: cmp_out <= 16'd0;
                    endcase
                end
                default: begin
                    shift_f <= 1'b1;
                    case (alu_fun[1:0])
                        2'b00: shift_out <= op_a >> 1;
                        2'b01: shift_out <= op_a << 1;
                        2'b10: shift_out <= op_b >> 1;
                        default: shift_out <= op_b << 1;
                    endcase
                end
            endcase
        end
    end

    task automatic drive_op(input logic [3:0] f, input logic [15:0] x, input logic [15:0] y);
        alu_issue = 1'b1; alu_fun = f; op_a = x; op_b = y;
        @(negedge clk);
    endtask

    task automatic idle();
        alu_issue = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; alu_issue = 1'b0; alu_fun = 4'h0; op_a = 16'h0; op_b = 16'h0;
        force_arith = 1'b0; res_ready = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", res_valid); end
        total++; if (res_data !== 16'h0) begin bad++; $display("FAIL rst_data got=%0h exp=0", res_data); end
        total++; if (res_fun !== 4'h0) begin bad++; $display("FAIL rst_fun got=%0h exp=0", res_fun); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL rst_issue_ready got=%0b exp=1", issue_ready); end
        total++; if ({flag_err, ovf_err, drop_cnt} !== 10'd0) begin bad++; $display("FAIL rst_errs got=%0b%0b/%0d exp=00/0", flag_err, ovf_err, drop_cnt); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_add();
        res_ready = 1'b1;
        drive_op(4'b0000, 16'd10, 16'd5);
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid got=%0b exp=0", res_valid); end
        idle();
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%0b exp=1", res_valid); end
        total++; if (res_data !== 16'd15) begin bad++; $display("FAIL add_data got=%0d exp=15", res_data); end
        total++; if (res_fun !== 4'b0000) begin bad++; $display("FAIL add_fun got=%0b exp=0000", res_fun); end
        total++; if (flag_err !== 1'b0) begin bad++; $display("FAIL add_flag_err got=%0b exp=0", flag_err); end
        idle();
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL add_popped got=%0b exp=0", res_valid); end
    endtask

    task automatic test_fill_overflow_drain();
        logic [15:0] exp_d [4];
        logic [3:0]  exp_f [4];
        exp_d = '{16'd5, 16'd12, 16'd5, 16'd2};
        exp_f = '{4'b0001, 4'b0010, 4'b0011, 4'b0100};
        res_ready = 1'b0;
        drive_op(4'b0001, 16'd10, 16'd5);
        drive_op(4'b0010, 16'd3, 16'd4);
        drive_op(4'b0011, 16'd20, 16'd4);
        drive_op(4'b0100, 16'd6, 16'd3);
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_pend got=%0b exp=0", issue_ready); end
        idle();
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", fifo_count); end
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%0b exp=0", issue_ready); end
        total++; if (res_data !== 16'd5) begin bad++; $display("FAIL fill_head_hold got=%0d exp=5", res_data); end
        drive_op(4'b0101, 16'd6, 16'd3);
        idle();
        total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%0b exp=1", ovf_err); end
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL drop_cnt_1 got=%0d exp=1", drop_cnt); end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
        total++; if (flag_err !== 1'b0) begin bad++; $display("FAIL ovf_flag_err got=%0b exp=0", flag_err); end
        for (int i = 0; i < 300; i++) drive_op(4'b0101, 16'd6, 16'd3);
        idle();
        total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL drop_cnt_sat got=%0d exp=255", drop_cnt); end
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (res_data !== exp_d[i] || res_fun !== exp_f[i]) begin bad++; $display("FAIL drain_%0d got=%0d/%0b exp=%0d/%0b", i, res_data, res_fun, exp_d[i], exp_f[i]); end
            @(negedge clk);
        end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0b exp=0", res_valid); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++; if ({ovf_err, drop_cnt} !== 9'd0) begin bad++; $display("FAIL ovf_clear got=%0b/%0d exp=0/0", ovf_err, drop_cnt); end
    endtask

    task automatic test_full_pop_push();
        logic [15:0] exp_d [4];
        exp_d = '{16'd4, 16'd6, 16'd8, 16'hFFF8};
        res_ready = 1'b0;
        drive_op(4'b0000, 16'd1, 16'd1);
        drive_op(4'b0000, 16'd2, 16'd2);
        drive_op(4'b0000, 16'd3, 16'd3);
        drive_op(4'b0000, 16'd4, 16'd4);
        idle();
        drive_op(4'b0111, 16'd6, 16'd3);
        res_ready = 1'b1;
        idle();
        res_ready = 1'b0;
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL fullpop_count got=%0d exp=4", fifo_count); end
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL fullpop_ovf got=%0b exp=0", ovf_err); end
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (res_data !== exp_d[i]) begin bad++; $display("FAIL fullpop_drain_%0d got=%0h exp=%0h", i, res_data, exp_d[i]); end
            if (i == 3) begin
                total++; if (res_fun !== 4'b0111) begin bad++; $display("FAIL fullpop_fun got=%0b exp=0111", res_fun); end
            end
            @(negedge clk);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_flag_err();
        force_arith = 1'b1;
        drive_op(4'b1010, 16'd5, 16'd3);
        idle();
        force_arith = 1'b0;
        total++; if (flag_err !== 1'b1) begin bad++; $display("FAIL flag_err_set got=%0b exp=1", flag_err); end
        total++; if (res_valid !== 1'b1 || res_data !== 16'd2) begin bad++; $display("FAIL flag_entry got=%0b/%0d exp=1/2", res_valid, res_data); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++; if (flag_err !== 1'b0) begin bad++; $display("FAIL flag_err_clr got=%0b exp=0", flag_err); end
        res_ready = 1'b1;
        idle();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0;
        drive_op(4'b0000, 16'd1, 16'd2);
        drive_op(4'b0000, 16'd2, 16'd3);
        idle();
        drive_op(4'b0000, 16'd7, 16'd7);
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL mid_pre_count got=%0d exp=2", fifo_count); end
        #2 rst = 1'b1;
        #1;
        total++; if (res_valid !== 1'b0 || fifo_count !== 3'd0) begin bad++; $display("FAIL mid_async got=%0b/%0d exp=0/0", res_valid, fifo_count); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%0b exp=1", issue_ready); end
        alu_issue = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle();
        idle();
        total++; if (res_valid !== 1'b0 || fifo_count !== 3'd0) begin bad++; $display("FAIL mid_after got=%0b/%0d exp=0/0", res_valid, fifo_count); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_fill_overflow_drain();
        test_full_pop_push();
        test_flag_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
